// File: rtl/keypad_scan_ctrl.sv
// Column-scan sequencer, row debouncer, key encoder and key-code FIFO for a 4x3 keypad.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_CYCLES cycles.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV      = 1000,
  parameter int DB_CYCLES     = 5000,
  parameter int REPEAT_CYCLES = 2000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [2:0] ROWS,
  output logic [3:0] COLS,
  output logic       KEY_VALID,
  output logic [3:0] KEY_DATA,
  input  logic       KEY_ACK,
  output logic       KEY_HELD,
  output logic       OVERFLOW
);

  if (SCAN_DIV < 2 || DB_CYCLES < 2 || REPEAT_CYCLES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_WAIT_RELEASE} state_t;

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [2:0]       r_rs_meta, r_rs;
  state_t           r_state, w_state_nx;
  logic [DIV_W-1:0] r_div, w_div_nx;
  logic [DB_W-1:0]  r_db, w_db_nx;
  logic [1:0]       r_col, w_col_nx;
  logic [2:0]       r_cap, w_cap_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] r_rep, w_rep_nx;
`endif

  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_full, w_pop, w_push, w_emit;
  logic [3:0]       w_code;

  // Priority C > A > E; column D carries *, 0, #.
  function automatic logic [3:0] encode(input logic [1:0] col, input logic [2:0] rs);
    logic [1:0] row;
    if (rs[2])      row = 2'd0;
    else if (rs[1]) row = 2'd1;
    else            row = 2'd2;
    unique case (col)
      2'd0:    encode = 4'd1 + {2'b00, row};
      2'd1:    encode = 4'd4 + {2'b00, row};
      2'd2:    encode = 4'd7 + {2'b00, row};
      default: encode = (row == 2'd0) ? 4'd10 : (row == 2'd1) ? 4'd0 : 4'd11;
    endcase
  endfunction

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_rs_meta <= '0;
      r_rs      <= '0;
    end else begin
      r_rs_meta <= ROWS;
      r_rs      <= r_rs_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state <= S_SCAN;
      r_div   <= '0;
      r_db    <= '0;
      r_col   <= '0;
      r_cap   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_db    <= w_db_nx;
      r_col   <= w_col_nx;
      r_cap   <= w_cap_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep   <= w_rep_nx;
`endif
    end
  end

  // NOTE: every next-state signal is defaulted first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_db_nx    = r_db;
    w_col_nx   = r_col;
    w_cap_nx   = r_cap;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep_nx   = '0;
`endif
    unique case (r_state)
      S_SCAN: begin
        w_db_nx = '0;
        if (r_div == DIV_LAST) begin
          w_div_nx = '0;
          if (r_rs != 3'b000) begin
            w_cap_nx   = r_rs;
            w_state_nx = S_DEBOUNCE;
          end else begin
            w_col_nx = r_col + 2'd1;
          end
        end else begin
          w_div_nx = r_div + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (r_rs != r_cap) begin
          w_state_nx = S_SCAN;
          w_div_nx   = '0;
          w_db_nx    = '0;
        end else if (r_db == DB_LAST) begin
          w_state_nx = S_EMIT;
          w_db_nx    = '0;
        end else begin
          w_db_nx = r_db + 1'b1;
        end
      end
      S_EMIT: begin
        w_state_nx = S_WAIT_RELEASE;
        w_db_nx    = '0;
      end
      S_WAIT_RELEASE: begin
        if (r_rs != 3'b000) begin
          w_db_nx = '0;
        end else if (r_db == DB_LAST) begin
          w_state_nx = S_SCAN;
          w_db_nx    = '0;
          w_div_nx   = '0;
          w_col_nx   = r_col + 2'd1;
        end else begin
          w_db_nx = r_db + 1'b1;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // A changed row pattern leaves w_rep_nx at its cleared default.
        if (r_rs == r_cap) begin
          if (r_rep == REP_LAST) w_state_nx = S_EMIT;
          else                   w_rep_nx   = r_rep + 1'b1;
        end
`endif
      end
      default: w_state_nx = S_SCAN;
    endcase
  end

  assign w_code = encode(r_col, r_cap);
  assign w_emit = (r_state == S_EMIT);
  assign w_full = (r_cnt == CNT_FULL);
  assign w_pop  = (r_cnt != '0) && KEY_ACK;
  assign w_push = w_emit && (!w_full || w_pop);

  // NOTE: the storage array is not reset; emptiness is tracked by r_cnt and KEY_DATA is gated on it.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= w_code;
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_emit && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign COLS      = 4'b1000 >> r_col;
  assign KEY_VALID = (r_cnt != '0);
  assign KEY_DATA  = KEY_VALID ? r_mem[r_rd] : 4'd0;
  assign KEY_HELD  = (r_state != S_SCAN);
  assign OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: emulated keypad, per-cycle behavioural model, directed and random presses.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV      = 4;
  localparam int DB_CYCLES     = 8;
  localparam int REPEAT_CYCLES = 32;
  localparam int FIFO_DEPTH    = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] ROWS;
  logic [3:0] COLS;
  logic       KEY_VALID;
  logic [3:0] KEY_DATA;
  logic       KEY_ACK;
  logic       KEY_HELD;
  logic       OVERFLOW;

  keypad_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(clk), .reset_n(reset_n), .ROWS(ROWS), .COLS(COLS),
    .KEY_VALID(KEY_VALID), .KEY_DATA(KEY_DATA), .KEY_ACK(KEY_ACK),
    .KEY_HELD(KEY_HELD), .OVERFLOW(OVERFLOW)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Emulated keypad: the pressed rows only return while their column is driven.
  logic       key_down = 1'b0;
  logic [1:0] key_col  = 2'd0;
  logic [2:0] key_rows = 3'b000;
  bit         rand_ack = 1'b0;

  // Behavioural model of the expected visible behaviour.
  typedef enum {M_SCAN, M_DEB, M_EMIT, M_WAIT} mphase_e;
  mphase_e    m_phase = M_SCAN;
  int         m_col, m_div, m_cnt, m_rep;
  logic [2:0] m_cap, m_s1, m_rs;
  logic [3:0] m_q[$];
  bit         m_ovf;
  bit         m_live = 1'b0;

  function automatic logic [3:0] key_code(input int col, input logic [2:0] rows);
    int row;
    row = rows[2] ? 0 : rows[1] ? 1 : 2;
    if (col < 3) return 4'(col * 3 + row + 1);
    return (row == 0) ? 4'd10 : (row == 1) ? 4'd0 : 4'd11;
  endfunction

  task automatic model_step();
    logic [2:0] rs;
    if (!reset_n) begin
      m_live = 1'b1; m_phase = M_SCAN;
      m_col = 0; m_div = 0; m_cnt = 0; m_rep = 0;
      m_cap = '0; m_s1 = '0; m_rs = '0; m_ovf = 1'b0;
      m_q.delete();
      return;
    end
    if (!m_live) return;
    rs   = m_rs;
    m_rs = m_s1;
    m_s1 = ROWS;
    if (m_q.size() != 0 && KEY_ACK) void'(m_q.pop_front());
    if (m_phase == M_EMIT) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(key_code(m_col, m_cap));
      else                         m_ovf = 1'b1;
    end
    case (m_phase)
      M_SCAN: begin
        if (m_div == SCAN_DIV - 1) begin
          m_div = 0;
          if (rs != 0) begin m_cap = rs; m_cnt = 0; m_phase = M_DEB; end
          else m_col = (m_col + 1) % 4;
        end else m_div++;
      end
      M_DEB: begin
        if (rs != m_cap) begin m_phase = M_SCAN; m_div = 0; end
        else if (m_cnt == DB_CYCLES - 1) m_phase = M_EMIT;
        else m_cnt++;
      end
      M_EMIT: begin m_phase = M_WAIT; m_cnt = 0; m_rep = 0; end
      default: begin
        if (rs != 0) m_cnt = 0;
        else if (m_cnt == DB_CYCLES - 1) begin
          m_phase = M_SCAN; m_col = (m_col + 1) % 4; m_div = 0;
        end else m_cnt++;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rs == m_cap) begin
          if (m_rep == REPEAT_CYCLES - 1) begin m_phase = M_EMIT; m_rep = 0; end
          else m_rep++;
        end else m_rep = 0;
`endif
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every output against the model once per cycle.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("cols", 32'(COLS), 32'(4'b1000 >> m_col));
      check("key_valid", 32'(KEY_VALID), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("key_data", 32'(KEY_DATA), 32'(m_q[0]));
      check("key_held", 32'(KEY_HELD), 32'(m_phase != M_SCAN));
      check("overflow", 32'(OVERFLOW), 32'(m_ovf));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    ROWS = (key_down && (COLS == (4'b1000 >> key_col))) ? key_rows : 3'b000;
    if (rand_ack) KEY_ACK = ($urandom_range(0, 2) == 0);
  endtask

  task automatic wait_held(input logic want, input int budget, input string name);
    int n = 0;
    while (KEY_HELD !== want && n < budget) begin step(); n++; end
    check({"wait_", name}, 32'(KEY_HELD === want), 32'd1);
  endtask

  task automatic press(input logic [1:0] col, input logic [2:0] rows, input int hold, input bit ack_on_emit);
    key_col = col; key_rows = rows; key_down = 1'b1;
    wait_held(1'b1, 200, "press");
    repeat (DB_CYCLES + 2 + hold) begin
      step();
      if (ack_on_emit) KEY_ACK = (m_phase == M_EMIT);
    end
    if (ack_on_emit) KEY_ACK = 1'b0;
    key_down = 1'b0;
    wait_held(1'b0, 300, "release");
  endtask

  task automatic pop_expect(input logic [3:0] exp, input string name);
    check({name, "_valid"}, 32'(KEY_VALID), 32'd1);
    check({name, "_data"}, 32'(KEY_DATA), 32'(exp));
    KEY_ACK = 1'b1;
    step();
    KEY_ACK = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (KEY_VALID && n < 16) begin KEY_ACK = 1'b1; step(); n++; end
    KEY_ACK = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; KEY_ACK = 1'b0; ROWS = 3'b000;
    repeat (3) step();
    reset_n = 1'b1;

    // Reset values and idle scan rotation.
    check("rst_valid", 32'(KEY_VALID), 32'd0);
    check("rst_data", 32'(KEY_DATA), 32'd0);
    check("rst_held", 32'(KEY_HELD), 32'd0);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);
    for (int k = 0; k < 16; k++) begin
      check("idle_cols", 32'(COLS), 32'(4'b1000 >> (k / 4)));
      step();
    end
    check("idle_cols_wrap", 32'(COLS), 32'(4'b1000));
    check("idle_valid", 32'(KEY_VALID), 32'd0);

    // Key 8: column F, row A.
    press(2'd2, 3'b010, 5, 1'b0);
    pop_expect(4'd8, "key8");
    check("key8_empty", 32'(KEY_VALID), 32'd0);

    // Bouncing C row on column B never debounces.
    n = 0;
    while (COLS !== 4'b1000 && n < 40) begin step(); n++; end
    check("wait_col_b", 32'(COLS), 32'(4'b1000));
    key_col = 2'd0; key_rows = 3'b100;
    for (int t = 0; t < 7; t++) begin
      key_down = (t % 2 == 0);
      repeat (3) step();
    end
    key_down = 1'b0;
    repeat (30) step();
    check("bounce_valid", 32'(KEY_VALID), 32'd0);
    check("bounce_held", 32'(KEY_HELD), 32'd0);

    // All rows on column D: C wins.
    press(2'd3, 3'b111, 2, 1'b0);
    pop_expect(4'd10, "prio");
    check("prio_empty", 32'(KEY_VALID), 32'd0);

    // Five presses without ack: fifth dropped.
    drain();
    press(2'd0, 3'b100, 0, 1'b0);
    press(2'd0, 3'b010, 0, 1'b0);
    press(2'd0, 3'b001, 0, 1'b0);
    press(2'd1, 3'b100, 0, 1'b0);
    press(2'd1, 3'b010, 0, 1'b0);
    check("ovf_set", 32'(OVERFLOW), 32'd1);
    pop_expect(4'd1, "ovf_q0");
    pop_expect(4'd2, "ovf_q1");
    pop_expect(4'd3, "ovf_q2");
    pop_expect(4'd4, "ovf_q3");
    check("ovf_empty", 32'(KEY_VALID), 32'd0);
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Fifth press with an ack on its EMIT cycle: nothing dropped.
    do_reset();
    check("ovf_cleared", 32'(OVERFLOW), 32'd0);
    press(2'd0, 3'b100, 0, 1'b0);
    press(2'd0, 3'b010, 0, 1'b0);
    press(2'd0, 3'b001, 0, 1'b0);
    press(2'd1, 3'b100, 0, 1'b0);
    press(2'd1, 3'b010, 0, 1'b1);
    check("full_pop_ovf", 32'(OVERFLOW), 32'd0);
    pop_expect(4'd2, "full_q0");
    pop_expect(4'd3, "full_q1");
    pop_expect(4'd4, "full_q2");
    pop_expect(4'd5, "full_q3");
    check("full_empty", 32'(KEY_VALID), 32'd0);

    // Reset during DEBOUNCE with a queued code.
    press(2'd3, 3'b010, 0, 1'b0);
    check("pre_rst_valid", 32'(KEY_VALID), 32'd1);
    key_col = 2'd2; key_rows = 3'b100; key_down = 1'b1;
    wait_held(1'b1, 200, "deb");
    step(); step();
    reset_n = 1'b0;
    key_down = 1'b0;
    step();
    check("mid_rst_cols", 32'(COLS), 32'(4'b1000));
    check("mid_rst_held", 32'(KEY_HELD), 32'd0);
    check("mid_rst_valid", 32'(KEY_VALID), 32'd0);
    reset_n = 1'b1;
    repeat (4) step();

    // Long hold of key 5.
    press(2'd1, 3'b010, 2 * REPEAT_CYCLES + 6, 1'b0);
    n = 0;
    while (KEY_VALID && n < 8) begin
      check("rep_data", 32'(KEY_DATA), 32'd5);
      KEY_ACK = 1'b1; step(); KEY_ACK = 1'b0;
      n++;
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    check("rep_count", 32'(n), 32'd3);
`else
    check("rep_count", 32'(n), 32'd1);
`endif

    // Random presses, taps, bounce and consumer acks.
    rand_ack = 1'b1;
    for (int it = 0; it < 30; it++) begin
      key_col  = 2'($urandom_range(0, 3));
      key_rows = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) begin
        key_down = 1'b1;
        repeat ($urandom_range(1, 12)) step();
        key_down = 1'b0;
        wait_held(1'b0, 300, "tap");
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          for (int b = 0; b < 4; b++) begin
            key_down = ~key_down;
            repeat ($urandom_range(1, 5)) step();
          end
        end
        press(key_col, key_rows, int'($urandom_range(0, 40)), 1'b0);
      end
      if (it == 15) do_reset();
      repeat ($urandom_range(0, 20)) step();
    end
    rand_ack = 1'b0;
    KEY_ACK  = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan sequencer and key-event buffer for the 4-column × 3-row keypad on the Basys3 PMOD. Drives one-hot column strobes at a divided rate, synchronizes and debounces the row returns, and encodes each debounced press into a 4-bit key code. Codes are queued in a small FIFO drained by the consumer (MCU port / display logic) through a valid/ack handshake.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is held before its rows are sampled (≥2).
- `DB_CYCLES`, default 5000: consecutive stable cycles required for press and for release (≥2).
- `REPEAT_CYCLES`, default 2000000: auto-repeat interval (used only with `KEYPAD_AUTOREPEAT_EN`).
- `FIFO_DEPTH`, default 4: key-code FIFO entries, power of 2, ≥2.
- `CLK` in 1: sole clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ROWS` in 3: async row returns; [2]=C, [1]=A, [0]=E, active-high.
- `COLS` out 4: one-hot column drive; [3]=B, [2]=G, [1]=F, [0]=D, active-high.
- `KEY_VALID` out 1: FIFO non-empty.
- `KEY_DATA` out 4: code at FIFO head (show-ahead).
- `KEY_ACK` in 1: consumer pops head when `KEY_VALID && KEY_ACK`.
- `KEY_HELD` out 1: high in DEBOUNCE/EMIT/WAIT_RELEASE.
- `OVERFLOW` out 1: sticky; set when a code is dropped because the FIFO is full.

## Operation
- `ROWS` passes through a 2-flop synchronizer. All decisions use the synced value `rs`.
- Column order: B→G→F→D→B. Column index is 0..3 with 0=B.
- Key map:
  - B: C=1, A=2, E=3
  - G: C=4, A=5, E=6
  - F: C=7, A=8, E=9
  - D: C=10 (*), A=0, E=11 (#)
- Multiple rows high: priority C > A > E.
- FSM states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
- SCAN: the divider counts 0..SCAN_DIV-1. At terminal count:
  - `rs`≠0: capture `rs` and the column, go to DEBOUNCE.
  - `rs`=0: advance the column and restart the divider.
- DEBOUNCE: `COLS` frozen.
  - `rs`≠captured: return to SCAN on the same column, divider and debounce counter cleared.
  - Counter reaches DB_CYCLES-1: go to EMIT.
- EMIT: single cycle. Push the encoded code, or set `OVERFLOW` if the FIFO is full and not popping. Go to WAIT_RELEASE.
- WAIT_RELEASE: `COLS` frozen. Requires `rs`=0 for DB_CYCLES consecutive cycles; any nonzero `rs` restarts the count. Then go to SCAN on the next column.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full: no overflow, occupancy unchanged.
  - `KEY_ACK` while empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- `OVERFLOW` clears only on reset.

## Timing
- Reset values:
  - `COLS`=4'b1000, `KEY_VALID`=0, `KEY_DATA`=0, `KEY_HELD`=0, `OVERFLOW`=0.
  - State SCAN, all counters 0, FIFO empty, synchronizer 0.
- Reset asserted mid-operation returns everything to the reset values on the next edge. A half-debounced key is discarded.
- A `ROWS` change is visible in `rs` 2 cycles later.
- `KEY_VALID` rises the cycle after EMIT when the FIFO was empty. Minimum press-to-valid is 2 + DB_CYCLES + 1 cycles after the sampling edge.
- `KEY_DATA` updates to the next entry the cycle after an accepted pop. `KEY_VALID` falls the cycle after the last pop.
- `KEY_HELD` rises the cycle after the sampling edge that enters DEBOUNCE.
- `COLS` changes exactly once per SCAN_DIV cycles while no key is held.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In WAIT_RELEASE with the captured `rs` still stable, a repeat counter reaching REPEAT_CYCLES-1 goes to EMIT, re-pushing the same code, and restarts the counter.
  - Any `rs` change resets the repeat counter.
- `KEYPAD_AUTOREPEAT_EN` undefined:
  - Exactly one code per press. No repeat counter is synthesized.

## Test plan
Parameters: SCAN_DIV=4, DB_CYCLES=8, FIFO_DEPTH=4, REPEAT_CYCLES=32.
- Reset, no rows → `COLS` cycles 1000→0100→0010→0001→1000, each held 4 cycles; `KEY_VALID`=0; `OVERFLOW`=0.
- Hold `ROWS`=3'b010 while `COLS`=0010 until release → exactly one code 8 queued; `KEY_VALID`=1; `KEY_ACK` pulse → `KEY_VALID`=0.
- Bounce: `ROWS`=3'b100 on column B, toggled every 3 cycles for 20 cycles, then released → no code queued; scanning resumes on B.
- `ROWS`=3'b111 on column D → code 10 (C priority).
- Five presses with no ack → codes 1,2,3,4 retained in order; 5th dropped; `OVERFLOW`=1. Fifth press with ack on its EMIT cycle → all five accepted, `OVERFLOW`=0.
- Reset asserted during DEBOUNCE → next cycle `COLS`=1000, `KEY_HELD`=0, FIFO empty.
- With `KEYPAD_AUTOREPEAT_EN`: hold key 5 for 8+32×2 cycles after debounce → 3 codes of 5.
- Without `KEYPAD_AUTOREPEAT_EN`: same stimulus → 1 code of 5.
